// File: rtl/shift_req_sequencer.sv
// rtl/shift_req_sequencer.sv - request FIFO and registered response front-end for the 8-bit right shifter
module shift_req_sequencer #(
  parameter int DEPTH = 2,
  parameter int LW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [7:0]    req_data,
  input  logic [2:0]    req_amt,
  input  logic          req_arith,
  output logic [7:0]    shf_in,
  output logic [2:0]    shf_ctrl,
  input  logic [7:0]    shf_out,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [7:0]    rsp_data,
  output logic          rsp_zero,
  output logic [LW:0]   level
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LW:0] DEPTH_LVL = DEPTH[LW:0];

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } rsp_state_t;

  // Each entry packs {data[7:0], amt[2:0], arith}
  logic [11:0]   mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  rsp_state_t    state;

  logic          push;
  logic          adv;
  logic          nonempty;
  logic [7:0]    head_data;
  logic [2:0]    head_amt;
  logic          head_arith;
  logic [7:0]    fill;
  logic [7:0]    result;

  assign nonempty  = (level != '0);
  // Ready depends only on occupancy, so rsp_ready never reaches req_ready
  assign req_ready = (level < DEPTH_LVL);
  assign push      = req_valid && req_ready;
  assign adv       = nonempty && (!rsp_valid || rsp_ready);

  assign {head_data, head_amt, head_arith} = mem[rptr];

  // Shifter sees zeros while idle so its inputs never carry stale entries
  assign shf_in   = nonempty ? head_data : 8'h00;
  assign shf_ctrl = nonempty ? head_amt  : 3'd0;

  // The shifter is logical only; sign fill covers the vacated upper bits
  assign fill   = (head_arith && head_data[7]) ? ~(8'hFF >> head_amt) : 8'h00;
  assign result = shf_out | fill;

  // Request storage write; contents need no reset because level gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= {req_data, req_amt, req_arith};
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); level tracks push/pop balance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (adv) begin
        rptr <= rptr + 1'b1;
      end
      case ({push, adv})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Result register: load on every advance, drain to EMPTY once consumed with nothing queued
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_EMPTY;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
      rsp_zero  <= 1'b0;
    end else begin
      case (state)
        S_EMPTY: begin
          if (adv) begin
            state     <= S_FULL;
            rsp_valid <= 1'b1;
            rsp_data  <= result;
            rsp_zero  <= (result == 8'h00);
          end
        end
        S_FULL: begin
          if (adv) begin
            rsp_data  <= result;
            rsp_zero  <= (result == 8'h00);
          end else if (rsp_ready) begin
            state     <= S_EMPTY;
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          state     <= S_EMPTY;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
